seq_logic_unit: RTL and testbench
=================================

# seq_logic_unit

Parametrised, multi-cycle bitwise logic unit for the ALU datapath. It generalises the fixed 32-bit single-op OR gate array to a configurable width and four selectable operations: AND, OR, XOR and NOR. It processes the operands one slice per cycle behind a start/busy/done handshake, and reports a registered zero flag for branch evaluation. It sits beside the adder in the execute stage and lets wide operands share narrow gate hardware.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle. N = WIDTH/SLICE; N >= 1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk in IDLE or DONE.
- op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while slices are being processed (RUN).
- done  output  1  one-cycle pulse; result and zero are valid.
- result  output  WIDTH  registered result.
- zero  output  1  high when the completed result is all zeros.

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst_n low, any time, asynchronous) forces the following, with no done pulse for an aborted operation:
  - state = IDLE, slice index k = 0;
  - busy = 0, done = 0, zero = 0;
  - result = 0;
  - captured operands and op = 0.
- IDLE:
  - start=1 captures a, b and op into internal registers, clears result to 0, clears zero, sets k = 0, and goes to RUN.
  - start=0 holds the state.
- RUN:
  - Each edge writes result[k*SLICE +: SLICE] = f(op_r, a_r slice k, b_r slice k) and increments k.
  - Slices are processed LSB first. Bits outside slice k are unchanged.
  - On the edge that writes slice N-1: go to DONE, register zero = (complete result == 0), and reset k to 0.
  - start is ignored in RUN; there is no error flag.
  - Changes on a, b or op during RUN have no effect.
- DONE:
  - done = 1 for exactly this one cycle.
  - start=1 recaptures exactly as in IDLE and goes to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- result and zero hold their values from DONE until the next capture.
- NOR is the bitwise inverse of OR per bit. No carries and no cross-slice dependencies.
- WIDTH not a multiple of SLICE is an elaboration error (generate-time check).

## Timing
- Latency: start sampled at edge E0. busy=1 after E0 through EN. done=1 and busy=0 after EN+1 for one cycle. This is N+1 edges from start to done; 5 edges for the defaults.
- busy and done are registered state decodes, never high together, and both low in IDLE.
- Throughput with start held high: one result every N+1 cycles.
- N=1 (SLICE=WIDTH): one RUN cycle, then DONE.
- zero and result are stable from the cycle done is high until the edge after the next start is sampled.

## Test plan
- Reset then idle: rst_n=0 mid-cycle → all outputs 0 immediately. Release it and hold start=0 for 10 cycles → outputs stay 0.
- OR, defaults:
  - Stimulus: a=0xF0F0_0000, b=0x0F0F_00FF, op=01, one start pulse.
  - Response: busy high for 4 cycles, then done for 1 cycle.
  - Values: result=0xFFFF_00FF, zero=0; result holds after done falls.
- Per-slice progression, XOR:
  - Stimulus: a=0xFFFF_FFFF, b=0x0000_0000, op=10.
  - Response after each RUN edge: result reads 0x0000_00FF, 0x0000_FFFF, 0x00FF_FFFF, 0xFFFF_FFFF.
  - Changing a during RUN does not alter these values.
- Zero flag and NOR/AND:
  - op=11 with a=b=0xFFFF_FFFF → result 0, zero=1.
  - Back-to-back start held high during DONE, op=00 with a=0x8000_0001, b=0x8000_0000 → result 0x8000_0000, zero=0, next done exactly 5 cycles later.
- Abort: rst_n pulsed low during the third RUN cycle → busy/done/result/zero 0. No done pulse follows. A new start then completes normally.
- Parameter sweep, WIDTH=16 with SLICE=16 and with SLICE=4:
  - Latency is 2 and 5 edges respectively.
  - Random a, b, op over 1000 operations match the bitwise reference model.

Source files
------------

// File: rtl/seq_logic_unit.sv
// seq_logic_unit: multi-cycle bitwise logic unit (AND/OR/XOR/NOR).
// Operands are captured on start and processed one SLICE-wide slice per
// cycle, LSB first. A registered zero flag is produced with the final slice.
module seq_logic_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("seq_logic_unit: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] sf;
  logic [WIDTH-1:0] res_next;

  // Slice k of the captured operands through the selected gate, merged into result
  always_comb begin
    sa = a_r[k*SLICE +: SLICE];
    sb = b_r[k*SLICE +: SLICE];
    case (op_r)
      OP_AND:  sf = sa & sb;
      OP_OR:   sf = sa | sb;
      OP_XOR:  sf = sa ^ sb;
      default: sf = ~(sa | sb);
    endcase
    res_next = result;
    res_next[k*SLICE +: SLICE] = sf;
  end

  // Control FSM, operand capture, slice write-back and zero flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      k      <= '0;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          result <= res_next;
          if (k == KLAST) begin
            state <= S_DONE;
            zero  <= (res_next == '0);
            k     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE share the capture path so start in DONE runs back-to-back
          if (start) begin
            state  <= S_RUN;
            a_r    <= a;
            b_r    <= b;
            op_r   <= op;
            result <= '0;
            zero   <= 1'b0;
            k      <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_logic_unit.sv
// tb_seq_logic_unit: directed checks of seq_logic_unit at default width plus
// a randomized sweep of two 16-bit configurations (SLICE=16 and SLICE=4).
module tb_seq_logic_unit;

  logic        clk;
  logic        rst_n;

  logic        start0;
  logic [1:0]  op0;
  logic [31:0] a0, b0;
  logic        busy0, done0, zero0;
  logic [31:0] r0;

  logic        starts;
  logic [1:0]  ops;
  logic [15:0] as, bs;
  logic        busy1, done1, zero1;
  logic [15:0] r1;
  logic        busy2, done2, zero2;
  logic [15:0] r2;

  int unsigned n_cmp;
  int unsigned n_bad;

  seq_logic_unit u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(op0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .result(r0), .zero(zero0)
  );

  seq_logic_unit #(.WIDTH(16), .SLICE(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(starts), .op(ops), .a(as), .b(bs),
    .busy(busy1), .done(done1), .result(r1), .zero(zero1)
  );

  seq_logic_unit #(.WIDTH(16), .SLICE(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(starts), .op(ops), .a(as), .b(bs),
    .busy(busy2), .done(done2), .result(r2), .zero(zero2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lop(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start an operation on u0 and check the busy window and the done cycle.
  // Returns positioned in the DONE cycle.
  task automatic run0(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp, input logic expz);
    start0 = 1'b1; op0 = o; a0 = x; b0 = y;
    tick();
    start0 = 1'b0;
    check("capture_clear", {30'd0, zero0, 1'b0} | r0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("busy_run", {30'd0, busy0, done0}, 32'd2);
      tick();
    end
    check("done_cycle", {30'd0, busy0, done0}, 32'd1);
    check("result", r0, exp);
    check("zero", {31'd0, zero0}, {31'd0, expz});
  endtask

  logic [31:0] xor_steps [4];
  logic [31:0] ea;
  logic [31:0] eb;
  logic [31:0] ex;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b1;
    start0 = 1'b0; op0 = 2'b00; a0 = '0; b0 = '0;
    starts = 1'b0; ops = 2'b00; as = '0; bs = '0;
    xor_steps[0] = 32'h0000_00FF;
    xor_steps[1] = 32'h0000_FFFF;
    xor_steps[2] = 32'h00FF_FFFF;
    xor_steps[3] = 32'hFFFF_FFFF;

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("rst_flags", {29'd0, busy0, done0, zero0}, 32'd0);
    check("rst_result", r0, 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_flags", {29'd0, busy0, done0, zero0}, 32'd0);
      check("idle_result", r0, 32'd0);
    end

    // OR with defaults; result holds after done falls
    run0(2'b01, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF, 1'b0);
    tick();
    check("or_after_done", {30'd0, busy0, done0}, 32'd0);
    check("or_hold", r0, 32'hFFFF_00FF);
    tick();

    // XOR slice-by-slice progression with inputs disturbed mid-run
    start0 = 1'b1; op0 = 2'b10; a0 = 32'hFFFF_FFFF; b0 = 32'h0;
    tick();
    start0 = 1'b0;
    a0 = 32'h1234_5678; op0 = 2'b00; b0 = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("xor_step", r0, xor_steps[i]);
    end
    check("xor_done", {31'd0, done0}, 32'd1);
    check("xor_zero", {31'd0, zero0}, 32'd0);
    tick();

    // NOR to zero, then back-to-back AND with start held during DONE
    run0(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    run0(2'b00, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 1'b0);
    tick();

    // Abort in the third RUN cycle
    start0 = 1'b1; op0 = 2'b01; a0 = 32'hFFFF_FFFF; b0 = 32'h0;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort_flags", {29'd0, busy0, done0, zero0}, 32'd0);
    check("abort_result", r0, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_done", {30'd0, busy0, done0}, 32'd0);
    end
    run0(2'b10, 32'hA5A5_A5A5, 32'h5A5A_0000, 32'hFFFF_A5A5, 1'b0);
    tick();

    // Parameter sweep: u1 (N=1, 2 edges) and u2 (N=4, 5 edges) in lockstep
    for (int n = 0; n < 1000; n++) begin
      ops = 2'($urandom_range(0, 3));
      as = 16'($urandom);
      bs = 16'($urandom);
      if (n == 0) begin ops = 2'b00; as = 16'hF0F0; bs = 16'h0F0F; end
      ea = {16'd0, as};
      eb = {16'd0, bs};
      ex = lop(ops, ea, eb) & 32'h0000_FFFF;
      starts = 1'b1;
      tick();
      starts = 1'b0;
      tick();
      check("s16_done", {30'd0, busy1, done1}, 32'd1);
      check("s16_result", {16'd0, r1}, ex);
      check("s16_zero", {31'd0, zero1}, {31'd0, (ex == 32'd0)});
      check("s4_running", {30'd0, busy2, done2}, 32'd2);
      tick();
      tick();
      check("s4_not_yet", {31'd0, done2}, 32'd0);
      tick();
      check("s4_done", {30'd0, busy2, done2}, 32'd1);
      check("s4_result", {16'd0, r2}, ex);
      check("s4_zero", {31'd0, zero2}, {31'd0, (ex == 32'd0)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
